// File: rtl/step_dir_decoder_if.sv
// -----------------------------------------------------------------------------
// step_dir_decoder_if
//
// Purpose: bundles the step/dir pin inputs, the clear command and the
// measurement results of step_dir_decoder into one interface.
//
// Signals:
//   step_in       step pulse from the board pin (asynchronous)
//   dir_in        direction from the board pin (asynchronous), 1 = up
//   clear         one-cycle command to zero the measurement state
//   position      signed step count (COUNT_BITS)
//   period        clk cycles between the last two accepted steps (PERIOD_BITS)
//   period_valid  period holds a genuine measurement
//   stalled       no accepted step for 2^PERIOD_BITS-1 cycles
//   step_strobe   one-cycle pulse per accepted step
//
// Modports:
//   master  drives the pins and clear, observes the results
//   slave   the decoder itself
// -----------------------------------------------------------------------------
interface step_dir_decoder_if #(
  parameter int COUNT_BITS  = 32,
  parameter int PERIOD_BITS = 24
);
  logic                   step_in;
  logic                   dir_in;
  logic                   clear;
  logic [COUNT_BITS-1:0]  position;
  logic [PERIOD_BITS-1:0] period;
  logic                   period_valid;
  logic                   stalled;
  logic                   step_strobe;

  modport master (
    output step_in, dir_in, clear,
    input  position, period, period_valid, stalled, step_strobe
  );

  modport slave (
    input  step_in, dir_in, clear,
    output position, period, period_valid, stalled, step_strobe
  );
endinterface

// File: rtl/step_dir_decoder.sv
// -----------------------------------------------------------------------------
// step_dir_decoder
//
// Purpose: receive side of a step/dir axis. Synchronizes the step and dir
// pins, de-glitches the step pulse, keeps a wrapping signed position count
// and measures the clk period between accepted steps (with stall detection).
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    step_dir_decoder_if.slave: step_in, dir_in, clear in;
//          position, period, period_valid, stalled, step_strobe out
//
// Parameters:
//   COUNT_BITS   width of the position counter
//   PERIOD_BITS  width of the period counter
//   PULSE_MIN    synchronized high cycles needed to accept a step (>= 1)
//
// Build option:
//   STEP_DECODER_GLITCH_FILTER_EN  when defined, a step must stay high for
//   PULSE_MIN synchronized cycles; otherwise the first synchronized high
//   cycle accepts the step and PULSE_MIN is ignored.
// -----------------------------------------------------------------------------
module step_dir_decoder #(
  parameter int COUNT_BITS  = 32,
  parameter int PERIOD_BITS = 24,
  parameter int PULSE_MIN   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  step_dir_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ARM      = 2'd2,
    HIGH     = 2'd3
  } state_t;

  localparam logic [PERIOD_BITS-1:0] PCNT_MAX = {PERIOD_BITS{1'b1}};
  localparam logic [PERIOD_BITS-1:0] PCNT_ONE = {{(PERIOD_BITS-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_BITS-1:0] PCNT_PRE = PCNT_MAX - PCNT_ONE;
  localparam logic [COUNT_BITS-1:0]  POS_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  logic                   step_meta_r;
  logic                   step_sync_r;
  logic                   dir_meta_r;
  logic                   dir_sync_r;
  logic [1:0]             sync_ok_r;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   accept_s;
  logic                   stall_hit_s;
  logic [PERIOD_BITS-1:0] pcnt_r;
  logic                   ref_r;
  logic [COUNT_BITS-1:0]  position_r;
  logic [PERIOD_BITS-1:0] period_r;
  logic                   period_valid_r;
  logic                   stalled_r;
  logic                   strobe_r;

`ifdef STEP_DECODER_GLITCH_FILTER_EN
  localparam int HCNT_BITS = (PULSE_MIN < 2) ? 1 : $clog2(PULSE_MIN + 1);
  localparam logic [HCNT_BITS:0] PMIN_W = PULSE_MIN[HCNT_BITS:0];
  localparam logic [HCNT_BITS-1:0] HCNT_ONE = {{(HCNT_BITS-1){1'b0}}, 1'b1};

  logic [HCNT_BITS-1:0] hcnt_r;
  logic [HCNT_BITS-1:0] hcnt_nxt_s;
  logic [HCNT_BITS:0]   hcnt_inc_s;

  // count of synchronized high cycles of the current pulse, including this one
  assign hcnt_inc_s = {1'b0, hcnt_r} + {{HCNT_BITS{1'b0}}, 1'b1};

  // high-cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r <= '0;
    end else begin
      hcnt_r <= hcnt_nxt_s;
    end
  end
`endif

  // two-flop synchronizers for step and dir, plus a fill marker so the
  // FSM ignores step_sync_r until it reflects a real post-reset sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
      dir_meta_r  <= 1'b0;
      dir_sync_r  <= 1'b0;
      sync_ok_r   <= 2'b00;
    end else begin
      step_meta_r <= bus.step_in;
      step_sync_r <= step_meta_r;
      dir_meta_r  <= bus.dir_in;
      dir_sync_r  <= dir_meta_r;
      sync_ok_r   <= {sync_ok_r[0], 1'b1};
    end
  end

  // filter FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_LOW;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // filter FSM next state and step acceptance
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
`ifdef STEP_DECODER_GLITCH_FILTER_EN
    hcnt_nxt_s  = hcnt_r;
`endif
    case (state_r)
      WAIT_LOW: begin
        // a pulse already high at reset release must fall before counting
        if (sync_ok_r[1] && !step_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_LOW;
        end
      end
      IDLE: begin
        if (step_sync_r) begin
`ifdef STEP_DECODER_GLITCH_FILTER_EN
          if (PULSE_MIN <= 1) begin
            accept_s    = 1'b1;
            state_nxt_s = HIGH;
          end else begin
            hcnt_nxt_s  = HCNT_ONE;
            state_nxt_s = ARM;
          end
`else
          accept_s    = 1'b1;
          state_nxt_s = HIGH;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARM: begin
        if (!step_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
`ifdef STEP_DECODER_GLITCH_FILTER_EN
          if (hcnt_inc_s >= PMIN_W) begin
            accept_s    = 1'b1;
            state_nxt_s = HIGH;
          end else begin
            hcnt_nxt_s  = hcnt_inc_s[HCNT_BITS-1:0];
            state_nxt_s = ARM;
          end
`else
          accept_s    = 1'b1;
          state_nxt_s = HIGH;
`endif
        end
      end
      HIGH: begin
        if (!step_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HIGH;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOW;
      end
    endcase
  end

  // the period counter hits saturation on this edge (an accept takes priority)
  assign stall_hit_s = !accept_s && !bus.clear && ref_r && (pcnt_r == PCNT_PRE);

  // position, period measurement, stall tracking and strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r         <= '0;
      ref_r          <= 1'b0;
      position_r     <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      stalled_r      <= 1'b0;
      strobe_r       <= 1'b0;
    end else begin
      strobe_r <= accept_s;

      // an accept restarts the interval even when it collides with clear
      if (accept_s) begin
        pcnt_r <= PCNT_ONE;
        ref_r  <= 1'b1;
      end else if (bus.clear) begin
        pcnt_r <= '0;
        ref_r  <= 1'b0;
      end else if (ref_r && (pcnt_r != PCNT_MAX)) begin
        pcnt_r <= pcnt_r + PCNT_ONE;
        ref_r  <= !stall_hit_s;
      end else begin
        pcnt_r <= pcnt_r;
        ref_r  <= ref_r;
      end

      if (bus.clear) begin
        position_r     <= '0;
        period_r       <= '0;
        period_valid_r <= 1'b0;
        stalled_r      <= 1'b0;
      end else if (accept_s) begin
        position_r     <= dir_sync_r ? (position_r + POS_ONE) : (position_r - POS_ONE);
        period_r       <= ref_r ? pcnt_r : period_r;
        period_valid_r <= ref_r;
        stalled_r      <= 1'b0;
      end else if (stall_hit_s) begin
        position_r     <= position_r;
        period_r       <= period_r;
        period_valid_r <= 1'b0;
        stalled_r      <= 1'b1;
      end else begin
        position_r     <= position_r;
        period_r       <= period_r;
        period_valid_r <= period_valid_r;
        stalled_r      <= stalled_r;
      end
    end
  end

  assign bus.position     = position_r;
  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.stalled      = stalled_r;
  assign bus.step_strobe  = strobe_r;

endmodule

// File: tb/tb_step_dir_decoder.sv
// -----------------------------------------------------------------------------
// tb_step_dir_decoder
//
// Directed bench for step_dir_decoder with PERIOD_BITS = 8. The driver pushes
// the hand-computed result of each step it issues into a queue; a monitor pops
// and compares on every step_strobe. Status outputs between steps are checked
// directly by the driver.
// -----------------------------------------------------------------------------
module tb_step_dir_decoder;
  localparam int COUNT_BITS  = 32;
  localparam int PERIOD_BITS = 8;
  localparam int PULSE_MIN   = 2;
`ifdef STEP_DECODER_GLITCH_FILTER_EN
  localparam int LAT = 1 + PULSE_MIN;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] pos;
    logic [7:0]  per;
    logic        pv;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   strobe_cnt;
  int   push_cnt;
  exp_t sb_q[$];

  step_dir_decoder_if #(.COUNT_BITS(COUNT_BITS), .PERIOD_BITS(PERIOD_BITS)) bus ();

  step_dir_decoder #(
    .COUNT_BITS (COUNT_BITS),
    .PERIOD_BITS(PERIOD_BITS),
    .PULSE_MIN  (PULSE_MIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_step(input logic [31:0] pos, input logic [7:0] per, input logic pv);
    exp_t e;
    e.pos = pos;
    e.per = per;
    e.pv  = pv;
    sb_q.push_back(e);
    push_cnt++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int high, input int low);
    bus.step_in = 1'b1;
    cycles(high);
    bus.step_in = 1'b0;
    cycles(low);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
  endtask

  // monitor: every strobe must match the oldest expected step
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.step_strobe) begin
      strobe_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual position=0x%0h required no strobe", bus.position);
      end else begin
        e = sb_q.pop_front();
        check("strobe_position", 64'(bus.position), 64'(e.pos));
        check("strobe_period", 64'(bus.period), 64'(e.per));
        check("strobe_period_valid", 64'(bus.period_valid), 64'(e.pv));
        check("strobe_stalled", 64'(bus.stalled), 64'd0);
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    strobe_cnt = 0;
    push_cnt   = 0;
    rst_n       = 1'b0;
    bus.step_in = 1'b0;
    bus.dir_in  = 1'b0;
    bus.clear   = 1'b0;

    // reset state
    cycles(2);
    check("rst_position", 64'(bus.position), 64'd0);
    check("rst_period", 64'(bus.period), 64'd0);
    check("rst_period_valid", 64'(bus.period_valid), 64'd0);
    check("rst_stalled", 64'(bus.stalled), 64'd0);
    check("rst_strobe", 64'(bus.step_strobe), 64'd0);
    rst_n = 1'b1;
    bus.dir_in = 1'b1;
    cycles(5);

    // positive steps, 40-cycle spacing
    expect_step(32'd1, 8'd0, 1'b0);
    for (int i = 2; i <= 5; i++) expect_step(32'(i), 8'd40, 1'b1);
    for (int i = 0; i < 5; i++) pulse(10, 30);
    check("pos_position", 64'(bus.position), 64'd5);
    check("pos_period", 64'(bus.period), 64'd40);
    check("pos_period_valid", 64'(bus.period_valid), 64'd1);

    // clear on its own
    bus.clear = 1'b1;
    cycles(1);
    bus.clear = 1'b0;
    check("clr_position", 64'(bus.position), 64'd0);
    check("clr_period", 64'(bus.period), 64'd0);
    check("clr_period_valid", 64'(bus.period_valid), 64'd0);
    cycles(5);

    // negative wrap from reset
    do_reset();
    bus.dir_in = 1'b0;
    cycles(5);
    expect_step(32'hFFFF_FFFF, 8'd0, 1'b0);
    expect_step(32'hFFFF_FFFE, 8'd25, 1'b1);
    expect_step(32'hFFFF_FFFD, 8'd25, 1'b1);
    for (int i = 0; i < 3; i++) pulse(5, 20);
    check("neg_position", 64'(bus.position), 64'hFFFF_FFFD);

    // one-cycle glitch
`ifdef STEP_DECODER_GLITCH_FILTER_EN
    pulse(1, 20);
    check("glitch_position", 64'(bus.position), 64'hFFFF_FFFD);
`else
    expect_step(32'hFFFF_FFFC, 8'd25, 1'b1);
    pulse(1, 20);
    check("glitch_position", 64'(bus.position), 64'hFFFF_FFFC);
`endif

    // stall and recovery
    do_reset();
    bus.dir_in = 1'b1;
    cycles(5);
    expect_step(32'd1, 8'd0, 1'b0);
    pulse(5, LAT + 249);
    check("stall_before_edge", 64'(bus.stalled), 64'd0);
    cycles(1);
    check("stall_at_edge", 64'(bus.stalled), 64'd1);
    check("stall_period_valid", 64'(bus.period_valid), 64'd0);
    cycles(300 - (LAT + 255));
    expect_step(32'd2, 8'd0, 1'b0);
    pulse(5, 45);
    check("recover_stalled", 64'(bus.stalled), 64'd0);
    expect_step(32'd3, 8'd50, 1'b1);
    pulse(5, 20);

    // reset asserted while step_in is high
    bus.step_in = 1'b1;
    cycles(3);
    rst_n = 1'b0;
    #1;
    check("midpulse_rst_position", 64'(bus.position), 64'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    bus.step_in = 1'b0;
    cycles(5);
    expect_step(32'd1, 8'd0, 1'b0);
    pulse(5, 10);
    check("held_high_position", 64'(bus.position), 64'd1);

    // clear colliding with an accept
    do_reset();
    bus.dir_in = 1'b1;
    cycles(5);
    expect_step(32'd1, 8'd0, 1'b0);
    for (int i = 2; i <= 7; i++) expect_step(32'(i), 8'd20, 1'b1);
    for (int i = 0; i < 7; i++) pulse(5, 15);
    check("pre_clear_position", 64'(bus.position), 64'd7);
    expect_step(32'd0, 8'd0, 1'b0);
    bus.step_in = 1'b1;
    cycles(LAT);
    bus.clear = 1'b1;
    cycles(1);
    bus.clear = 1'b0;
    check("collide_position", 64'(bus.position), 64'd0);
    check("collide_period_valid", 64'(bus.period_valid), 64'd0);
    cycles(4 - LAT);
    bus.step_in = 1'b0;
    cycles(25);
    expect_step(32'd1, 8'd30, 1'b1);
    pulse(5, 20);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("strobe_count", 64'(strobe_cnt), 64'(push_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receive-side counterpart of the step-pulse generator. Takes an external step/dir pulse pair, synchronizes and de-glitches it, and keeps a signed position count. It also measures the period between accepted steps in clock cycles, which lets the design read back an axis driven by another controller and loop-test its own step generator output. It sits between the board step/dir input pins and the register file.

## Interface
Parameters:
- COUNT_BITS, 32, width of position counter (two's complement, wraps).
- PERIOD_BITS, 24, width of period measurement counter.
- PULSE_MIN, 2, minimum synchronized high cycles for a step to be accepted (≥1; used only with filter compiled in).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- step_in  in  1  asynchronous step pulse; rising edge = one step.
- dir_in  in  1  asynchronous direction; 1 = increment, 0 = decrement.
- clear  in  1  synchronous, one-cycle command to zero the measurement state.
- position  out  COUNT_BITS  signed step count.
- period  out  PERIOD_BITS  clk cycles between the last two accepted steps.
- period_valid  out  1  period holds a genuine measurement.
- stalled  out  1  no step for 2^PERIOD_BITS−1 cycles since the last accepted step.
- step_strobe  out  1  one-cycle pulse per accepted step.

## Operation
- step_in and dir_in each pass through a 2-flop synchronizer (step_s, dir_s); the synchronizer flops reset to 0.
- Filter FSM, states:
  - WAIT_LOW: reset state; go to IDLE when step_s = 0.
  - IDLE: on step_s = 1 go to ARM with hcnt = 1.
  - ARM: if step_s = 0, return to IDLE with no count. If hcnt = PULSE_MIN, accept the step and go to HIGH. Otherwise increment hcnt.
  - HIGH: go to IDLE when step_s = 0.
- Because reset enters WAIT_LOW, a pulse already high at reset release is never counted.
- On accept, in a single edge:
  - step_strobe = 1.
  - position ± 1, with the direction taken from dir_s on that edge; wraps modulo 2^COUNT_BITS.
- Period counter pcnt:
  - Set to 1 on every accepted step; increments every cycle afterward.
  - Saturates at 2^PERIOD_BITS−1. On reaching saturation: stalled = 1, period_valid = 0, and the reference is dropped.
- On an accept with a valid reference: period = pcnt and period_valid = 1.
- On an accept without a reference (first step after reset, clear, or stall): period is unchanged, period_valid = 0, stalled = 0, and that step becomes the reference.
- clear sets position = 0, period = 0, period_valid = 0 and stalled = 0, and drops the reference. Filter FSM and synchronizers are unaffected.
- clear and accept on the same edge:
  - position = 0, not ±1.
  - step_strobe still pulses.
  - The step becomes the reference and period_valid = 0.

## Timing
- Reset values: position 0, period 0, period_valid 0, stalled 0, step_strobe 0.
- E0 is the first clk edge that samples step_in = 1. step_strobe and position update on edge E(1+PULSE_MIN); without the filter, on E2.
- dir_in must be stable for ≥3 clk cycles before step_in rises and while the step is being accepted.
- The minimum accepted low time is 1 synchronized cycle.
- period is measured edge-to-edge: accepts on edges A and B give period = B−A.
- stalled asserts on the edge where pcnt reaches 2^PERIOD_BITS−1.
- Reset assertion mid-pulse takes effect immediately; after release the decoder waits in WAIT_LOW.

## Configuration
- STEP_DECODER_GLITCH_FILTER_EN defined:
  - ARM enforces PULSE_MIN as described.
- Not defined:
  - PULSE_MIN is ignored and ARM accepts on its first cycle (equivalent to PULSE_MIN = 1).
  - hcnt logic is removed.
  - Latency becomes E2.

## Test plan
- Positive steps: filter on, PULSE_MIN=2; 5 pulses, 10 cycles high, 40-cycle spacing, dir=1 -> position 5, period 40, period_valid 1, exactly 5 step_strobe pulses.
- Negative wrap: from reset, 3 pulses with dir=0 -> position 0xFFFFFFFD; period_valid 1 after the 2nd pulse.
- Glitch rejection: 1-cycle step_in pulse with PULSE_MIN=2 -> position unchanged, no strobe. With the macro undefined, the same pulse -> position 1.
- Stall recovery (PERIOD_BITS=8):
  - 300-cycle gap -> stalled=1 after 255 cycles, period_valid 0.
  - Next step -> stalled 0, period_valid still 0.
  - Following step 50 cycles later -> period 50, period_valid 1.
- Reset with step held high: assert rst_n low while step_in=1, release, hold step_in high 20 cycles -> no strobe. Then low 5 and high 5 cycles -> position 1.
- Clear collision: clear asserted on the accept edge with position 7 -> position 0, strobe 1, period_valid 0. Next step 30 cycles later -> period 30, position ±1.
